// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and load/store.
// Round-robin on contention, one outstanding transfer, bounded wait with error completion.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch (read-only)
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  // load/store
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_wstrb,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  // shared memory
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_wstrb,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;   // 1: last grant went to D
  logic [7:0]      cnt_q, cnt_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [3:0]      m_wstrb_q, m_wstrb_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic            d_ack_q, d_ack_d, d_err_q, d_err_d;

  logic i_elig, d_elig, gnt_i, gnt_d, busy, tmo;

  // A requester whose completion is being signalled still shows its old req.
  assign i_elig = i_req && !i_ack_q && !i_err_q;
  assign d_elig = d_req && !d_ack_q && !d_err_q;
  assign gnt_d  = (state_q == IDLE) && d_elig && (!i_elig || !last_d_q);
  assign gnt_i  = (state_q == IDLE) && i_elig && !gnt_d;
  assign busy   = (state_q != IDLE);
  assign tmo    = busy && !m_ack && (cnt_q == TMO_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_d) state_d = BUSY_D;
               else if (gnt_i) state_d = BUSY_I;
      BUSY_I,
      BUSY_D:  if (m_ack || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs and datapath
  always_comb begin
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    if (gnt_d) begin
      last_d_d  = 1'b1;
      cnt_d     = '0;
      m_req_d   = 1'b1;
      m_we_d    = d_we;
      m_wstrb_d = d_wstrb;
      m_addr_d  = d_addr;
      m_wdata_d = d_wdata;
    end else if (gnt_i) begin
      last_d_d  = 1'b0;
      cnt_d     = '0;
      m_req_d   = 1'b1;
      m_we_d    = 1'b0;
      m_wstrb_d = '0;
      m_addr_d  = i_addr;
      m_wdata_d = '0;
    end else if (busy) begin
      if (m_ack) begin
        // ack beats a coinciding timeout
        m_req_d = 1'b0;
        if (state_q == BUSY_D) begin
          d_ack_d = 1'b1;
          if (!m_we_q) d_rdata_d = m_rdata;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = m_rdata;
        end
      end else if (tmo) begin
        m_req_d = 1'b0;
        if (state_q == BUSY_D) d_err_d = 1'b1;
        else                   i_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;

endmodule
